launch_aim_ctrl: RTL and testbench

Parametrised aiming and launch controller for the ball-thrower game. It holds a bounded angle index and power level, adjusted by five active-low pushbuttons with auto-repeat. It draws an aim marker on the VGA raster from a polar lookup, and hands the launch vector to the ball-physics block over a valid/ready handshake. It sits between the board buttons, the VGA pixel mux and the ball engine, and runs on a single clock with a game-tick enable.

---
 rtl/aim_pkg.sv | 38 +++
 rtl/launch_aim_ctrl_if.sv | 14 +
 rtl/launch_aim_ctrl_btn_repeat.sv | 73 +++++++
 rtl/launch_aim_ctrl.sv | 122 ++++++++++++
 tb/tb_launch_aim_ctrl.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aim_pkg.sv
// Shared types and constants for the launch/aim controller: FSM states,
// button indices and the quarter-circle marker lookup (scale 64, 6-degree steps).
package aim_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_REPEAT,
    S_LAUNCH,
    S_FLIGHT,
    S_WAITREL
  } state_t;

  localparam logic [2:0] BTN_AUP  = 3'd0;
  localparam logic [2:0] BTN_ADN  = 3'd1;
  localparam logic [2:0] BTN_PUP  = 3'd2;
  localparam logic [2:0] BTN_PDN  = 3'd3;
  localparam logic [2:0] BTN_FIRE = 3'd4;

  localparam logic [6:0] COS_TAB [0:15] = '{
    7'd64, 7'd64, 7'd63, 7'd61, 7'd58, 7'd55, 7'd52, 7'd48,
    7'd43, 7'd38, 7'd32, 7'd26, 7'd20, 7'd13, 7'd7,  7'd0
  };
  localparam logic [6:0] SIN_TAB [0:15] = '{
    7'd0,  7'd7,  7'd13, 7'd20, 7'd26, 7'd32, 7'd38, 7'd43,
    7'd48, 7'd52, 7'd55, 7'd58, 7'd61, 7'd63, 7'd64, 7'd64
  };

  // Fire wins over everything, then angle before power, up before down.
  function automatic logic [2:0] pick_btn(input logic [4:0] pressed);
    if (pressed[BTN_FIRE])     return BTN_FIRE;
    else if (pressed[BTN_AUP]) return BTN_AUP;
    else if (pressed[BTN_ADN]) return BTN_ADN;
    else if (pressed[BTN_PUP]) return BTN_PUP;
    else                       return BTN_PDN;
  endfunction

endpackage

// File: rtl/launch_aim_ctrl_if.sv
// Launch bus between the aim controller (master) and the ball engine (slave).
interface launch_aim_ctrl_if;
  logic       launch_valid;
  logic       launch_ready;
  logic       busy;
  logic       ball_done;
  logic [3:0] angle;
  logic [3:0] power;

  modport master (output launch_valid, busy, angle, power,
                  input  launch_ready, ball_done);
  modport slave  (input  launch_valid, busy, angle, power,
                  output launch_ready, ball_done);
endinterface

// File: rtl/launch_aim_ctrl_btn_repeat.sv
// Button front end: 2-flop synchronisers, release-edge qualification and the
// hold/auto-repeat counter; emits one-tick step pulses tagged with a button id.
module btn_repeat
  import aim_pkg::*;
#(
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_RATE  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [4:0] btn_n,
  input  state_t     state,
  output logic       press,
  output logic [2:0] press_id,
  output logic       release_evt,
  output logic       hold_done,
  output logic       all_rel,
  output logic       step,
  output logic [2:0] step_id
);

  logic [4:0] sync_p0, sync_p1;
  logic [4:0] pressed;
  logic       rel_prev;
  logic [2:0] latch_id;
  logic [7:0] cnt, cnt_inc;
  logic       held, rpt_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0  <= '1;
      sync_p1  <= '1;
      rel_prev <= 1'b1;
      latch_id <= BTN_AUP;
      cnt      <= '0;
    end else begin
      sync_p0 <= btn_n;
      sync_p1 <= sync_p0;
      if (tick) begin
        rel_prev <= ~|pressed;
        if (state == S_IDLE && press) latch_id <= press_id;
        if ((state == S_HOLD || state == S_REPEAT) && held && !hold_done && !rpt_hit)
          cnt <= cnt_inc;
        else
          cnt <= '0;
      end
    end
  end

  assign pressed     = ~sync_p1;
  assign held        = pressed[latch_id];
  assign cnt_inc     = cnt + 8'd1;
  assign press       = tick && rel_prev && |pressed;
  assign press_id    = pick_btn(pressed);
  assign release_evt = tick && !held;
  assign all_rel     = tick && ~|pressed;
  assign hold_done   = tick && held && state == S_HOLD   && cnt_inc == 8'(REPEAT_DELAY);
  assign rpt_hit     = tick && held && state == S_REPEAT && cnt_inc == 8'(REPEAT_RATE);

  // A fresh press steps immediately; later steps come from the latched button.
  always_comb begin
    step    = 1'b0;
    step_id = latch_id;
    if (state == S_IDLE) begin
      step    = press && press_id != BTN_FIRE;
      step_id = press_id;
    end else if (hold_done || rpt_hit) begin
      step = 1'b1;
    end
  end

endmodule

// File: rtl/launch_aim_ctrl.sv
// Aim/launch controller: button-driven angle and power, launch handshake to the
// ball engine, and a VGA aim marker placed from the polar lookup.
module launch_aim_ctrl
  import aim_pkg::*;
#(
  parameter int ANGLE_STEPS  = 16,
  parameter int ANGLE_INIT   = 8,
  parameter int POWER_MIN    = 1,
  parameter int POWER_MAX    = 15,
  parameter int POWER_INIT   = 8,
  parameter int STEP_PX      = 8,
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_RATE  = 2,
  parameter int ORIGIN_X     = 75,
  parameter int ORIGIN_Y     = 385,
  parameter int MARKER       = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick,
  input  logic                    btn_aup_n,
  input  logic                    btn_adn_n,
  input  logic                    btn_pup_n,
  input  logic                    btn_pdn_n,
  input  logic                    btn_fire_n,
  input  logic [9:0]              x_count,
  input  logic [9:0]              y_count,
  launch_aim_ctrl_if.master       lb,
  output logic                    arrow
);

  state_t     state, state_nx;
  logic       press, release_evt, hold_done, all_rel, step;
  logic [2:0] press_id, step_id;
  logic [3:0] angle_r, power_r;
  logic [13:0] dx_full, dy_full;
  logic [9:0] mx_p0, my_p0;

  function automatic logic [3:0] sat_step(input logic [3:0] v, input logic up,
                                          input logic [3:0] lo, input logic [3:0] hi);
    if (up) return (v >= hi) ? hi : v + 4'd1;
    else    return (v <= lo) ? lo : v - 4'd1;
  endfunction

  btn_repeat #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) u_btn (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .btn_n       ({btn_fire_n, btn_pdn_n, btn_pup_n, btn_adn_n, btn_aup_n}),
    .state       (state),
    .press       (press),
    .press_id    (press_id),
    .release_evt (release_evt),
    .hold_done   (hold_done),
    .all_rel     (all_rel),
    .step        (step),
    .step_id     (step_id)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:    if (press) state_nx = (press_id == BTN_FIRE) ? S_LAUNCH : S_HOLD;
      S_HOLD:    if (release_evt) state_nx = S_IDLE;
                 else if (hold_done) state_nx = S_REPEAT;
      S_REPEAT:  if (release_evt) state_nx = S_IDLE;
      S_LAUNCH:  if (lb.launch_ready) state_nx = S_FLIGHT;
      S_FLIGHT:  if (lb.ball_done) state_nx = S_WAITREL;
      S_WAITREL: if (all_rel) state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    lb.launch_valid = (state == S_LAUNCH);
    lb.busy         = (state == S_FLIGHT);
  end

  // Steps only arrive in IDLE/HOLD/REPEAT, so the vector is frozen while launching.
  always_ff @(posedge clk) begin
    if (rst) begin
      angle_r <= 4'(ANGLE_INIT);
      power_r <= 4'(POWER_INIT);
    end else if (step) begin
      case (step_id)
        BTN_AUP: angle_r <= sat_step(angle_r, 1'b1, 4'd0, 4'(ANGLE_STEPS - 1));
        BTN_ADN: angle_r <= sat_step(angle_r, 1'b0, 4'd0, 4'(ANGLE_STEPS - 1));
        BTN_PUP: power_r <= sat_step(power_r, 1'b1, 4'(POWER_MIN), 4'(POWER_MAX));
        BTN_PDN: power_r <= sat_step(power_r, 1'b0, 4'(POWER_MIN), 4'(POWER_MAX));
        default: ;
      endcase
    end
  end

  assign lb.angle = angle_r;
  assign lb.power = power_r;

  assign dx_full = (14'(COS_TAB[angle_r]) * 14'(power_r) * 14'(STEP_PX)) >> 6;
  assign dy_full = (14'(SIN_TAB[angle_r]) * 14'(power_r) * 14'(STEP_PX)) >> 6;

  // Stage p0: marker corner
  always_ff @(posedge clk) begin
    mx_p0 <= 10'(14'(ORIGIN_X) + dx_full);
    my_p0 <= 10'(14'(ORIGIN_Y) - dy_full);
  end

  // Stage p1: raster hit test
  always_ff @(posedge clk) begin
    if (rst) arrow <= 1'b0;
    else     arrow <= (x_count >= mx_p0) && ({1'b0, x_count} < 11'(mx_p0) + 11'(MARKER)) &&
                      (y_count >= my_p0) && ({1'b0, y_count} < 11'(my_p0) + 11'(MARKER));
  end

endmodule

// File: tb/tb_launch_aim_ctrl.sv
// Self-checking bench for launch_aim_ctrl: directed scenarios plus randomized
// button holds compared against an arithmetic model of steps, saturation and marker.
module tb_launch_aim_ctrl;

  localparam int DELAY = 8;
  localparam int RATE  = 2;
  localparam real PI   = 3.14159265358979;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       btn_aup_n = 1'b1, btn_adn_n = 1'b1, btn_pup_n = 1'b1;
  logic       btn_pdn_n = 1'b1, btn_fire_n = 1'b1;
  logic [9:0] x_count = '0, y_count = '0;
  logic       arrow;

  int errors = 0;
  int checks = 0;
  int m_angle = 8;
  int m_power = 8;

  launch_aim_ctrl_if lb ();

  launch_aim_ctrl u_dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .btn_aup_n  (btn_aup_n),
    .btn_adn_n  (btn_adn_n),
    .btn_pup_n  (btn_pup_n),
    .btn_pdn_n  (btn_pdn_n),
    .btn_fire_n (btn_fire_n),
    .x_count    (x_count),
    .y_count    (y_count),
    .lb         (lb),
    .arrow      (arrow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  // Steps produced after a button has been seen pressed on l consecutive ticks.
  function automatic int n_steps(input int l);
    if (l <= 0) return 0;
    if (l - 1 < DELAY) return 1;
    return 2 + (l - 1 - DELAY) / RATE;
  endfunction

  function automatic int trig(input int i, input bit is_sin);
    real a;
    a = i * 6.0 * PI / 180.0;
    return $rtoi(64.0 * (is_sin ? $sin(a) : $cos(a)) + 0.5);
  endfunction

  function automatic int mark_x(input int ang, input int pow);
    return 75 + ((trig(ang, 1'b0) * pow * 8) >> 6);
  endfunction

  function automatic int mark_y(input int ang, input int pow);
    return 385 - ((trig(ang, 1'b1) * pow * 8) >> 6);
  endfunction

  function automatic int exp_arrow(input int x, input int y);
    int mx, my;
    mx = mark_x(m_angle, m_power);
    my = mark_y(m_angle, m_power);
    return (x >= mx && x < mx + 10 && y >= my && y < my + 10) ? 1 : 0;
  endfunction

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    clks(2);
  endtask

  // mask bits: 0 aup, 1 adn, 2 pup, 3 pdn, 4 fire
  task automatic set_btn(input logic [4:0] m);
    btn_aup_n  = ~m[0];
    btn_adn_n  = ~m[1];
    btn_pup_n  = ~m[2];
    btn_pdn_n  = ~m[3];
    btn_fire_n = ~m[4];
    clks(3);
  endtask

  task automatic press_hold(input logic [4:0] m, input int len, input int gap);
    int id, a0, p0, n, ea, ep;
    id = m[0] ? 0 : m[1] ? 1 : m[2] ? 2 : 3;
    a0 = m_angle;
    p0 = m_power;
    ea = a0;
    ep = p0;
    set_btn(m);
    for (int k = 0; k < len; k++) begin
      pulse_tick();
      n  = n_steps(k + 1);
      ea = a0;
      ep = p0;
      case (id)
        0:       ea = clamp(a0 + n, 0, 15);
        1:       ea = clamp(a0 - n, 0, 15);
        2:       ep = clamp(p0 + n, 1, 15);
        default: ep = clamp(p0 - n, 1, 15);
      endcase
      chk("angle_hold", int'(lb.angle), ea);
      chk("power_hold", int'(lb.power), ep);
    end
    m_angle = ea;
    m_power = ep;
    set_btn(5'b0);
    repeat (gap) pulse_tick();
    chk("angle_rel", int'(lb.angle), m_angle);
    chk("power_rel", int'(lb.power), m_power);
  endtask

  task automatic chk_px(input int x, input int y, input int exp);
    x_count = 10'(x);
    y_count = 10'(y);
    @(negedge clk);
    chk("arrow", int'(arrow), exp);
  endtask

  initial begin
    int a0, p0, x, y;
    lb.launch_ready = 1'b0;
    lb.ball_done    = 1'b0;

    clks(3);
    chk("rst_angle", int'(lb.angle), 8);
    chk("rst_power", int'(lb.power), 8);
    chk("rst_valid", int'(lb.launch_valid), 0);
    chk("rst_busy", int'(lb.busy), 0);
    chk("rst_arrow", int'(arrow), 0);
    rst = 1'b0;
    clks(2);

    // Angle 0, power 8: marker square at x 139..148, y 385..394
    repeat (8) press_hold(5'b00010, 1, 1);
    chk("angle_zero", int'(lb.angle), 0);
    foreach (x_count[i]) ;
    for (int i = 0; i < 6; i++) begin
      x = 137 + i * 3;
      chk_px(x, 385, (x >= 139 && x <= 148) ? 1 : 0);
    end
    chk_px(148, 394, 1);
    chk_px(149, 390, 0);
    chk_px(143, 395, 0);
    chk_px(143, 384, 0);

    press_hold(5'b00100, 20, 1);
    chk("power_sat", int'(lb.power), 15);
    press_hold(5'b01000, 1, 1);
    chk("power_pdn", int'(lb.power), 14);

    repeat (20) press_hold(5'b00001, 1, 1);
    chk("angle_max", int'(lb.angle), 15);
    repeat (20) press_hold(5'b00010, 1, 1);
    chk("angle_min", int'(lb.angle), 0);

    press_hold(5'b00101, 1, 1);
    chk("prio_angle", int'(lb.angle), 1);
    chk("prio_power", int'(lb.power), 14);

    // pdn joining while aup is held is ignored
    set_btn(5'b00001);
    pulse_tick();
    set_btn(5'b01001);
    repeat (3) pulse_tick();
    chk("other_btn_angle", int'(lb.angle), 2);
    chk("other_btn_power", int'(lb.power), 14);
    set_btn(5'b0);
    pulse_tick();
    m_angle = 2;

    for (int it = 0; it < 40; it++) begin
      press_hold(5'($urandom_range(1, 15)), $urandom_range(1, 20), $urandom_range(1, 3));
      for (int j = 0; j < 3; j++) begin
        x = mark_x(m_angle, m_power) + $urandom_range(0, 13) - 2;
        y = mark_y(m_angle, m_power) + $urandom_range(0, 13) - 2;
        chk_px(x, y, exp_arrow(x, y));
      end
    end

    // Launch with ready held low for 5 valid cycles
    a0 = m_angle;
    p0 = m_power;
    lb.launch_ready = 1'b0;
    set_btn(5'b10000);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("launch_valid", int'(lb.launch_valid), 1);
      chk("launch_angle", int'(lb.angle), a0);
      chk("launch_power", int'(lb.power), p0);
      if (i == 0) btn_aup_n = 1'b0;
      if (i == 3) tick = 1'b1;
      if (i == 4) tick = 1'b0;
      if (i == 5) lb.launch_ready = 1'b1;
      @(negedge clk);
    end
    lb.launch_ready = 1'b0;
    chk("after_valid", int'(lb.launch_valid), 0);
    chk("after_busy", int'(lb.busy), 1);
    chk("after_angle", int'(lb.angle), a0);
    pulse_tick();
    chk("flight_busy", int'(lb.busy), 1);
    chk("flight_angle", int'(lb.angle), a0);

    lb.ball_done = 1'b1;
    @(negedge clk);
    lb.ball_done = 1'b0;
    chk("done_busy", int'(lb.busy), 0);
    repeat (2) pulse_tick();
    chk("waitrel_valid", int'(lb.launch_valid), 0);
    chk("waitrel_angle", int'(lb.angle), a0);
    chk("waitrel_busy", int'(lb.busy), 0);

    set_btn(5'b0);
    pulse_tick();
    lb.ball_done = 1'b1;
    @(negedge clk);
    lb.ball_done = 1'b0;
    chk("idle_done_ignored", int'(lb.busy), 0);

    // Ready already high: one-cycle transfer
    lb.launch_ready = 1'b1;
    set_btn(5'b10000);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    chk("fast_valid", int'(lb.launch_valid), 1);
    @(negedge clk);
    chk("fast_valid_drop", int'(lb.launch_valid), 0);
    chk("fast_busy", int'(lb.busy), 1);
    lb.launch_ready = 1'b0;
    lb.ball_done = 1'b1;
    @(negedge clk);
    lb.ball_done = 1'b0;
    set_btn(5'b0);
    pulse_tick();

    // Reset while a launch is pending
    set_btn(5'b10000);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    chk("pre_rst_valid", int'(lb.launch_valid), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_launch_valid", int'(lb.launch_valid), 0);
    chk("rst_launch_busy", int'(lb.busy), 0);
    chk("rst_launch_angle", int'(lb.angle), 8);
    chk("rst_launch_power", int'(lb.power), 8);
    rst = 1'b0;
    m_angle = 8;
    m_power = 8;
    set_btn(5'b0);
    pulse_tick();
    press_hold(5'b00100, 3, 1);
    chk("post_rst_power", int'(lb.power), 9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
